// File: rtl/nrisc_program_loader.sv
// Byte-stream boot loader for nRisc: parses framed segments, writes them into
// instruction/data memory and releases the CPU after a valid end-of-program byte.
module nrisc_program_loader #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] InData,
  input  logic              InValid,
  output logic              InReady,
  output logic              WrEn,
  output logic              WrSel,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [DATA_W-1:0] WrData,
  output logic              CpuRun,
  output logic              Done,
  output logic              Error,
  output logic [1:0]        ErrCode
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_HDR, S_CNT, S_ADDR, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            state_reg, state_next;
  logic              inready_reg, inready_next;
  logic              wren_reg, wren_next;
  logic              wrsel_reg, wrsel_next;
  logic [ADDR_W-1:0] wraddr_reg, wraddr_next;
  logic [DATA_W-1:0] wrdata_reg, wrdata_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [DATA_W:0]   cnt_reg, cnt_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [TW-1:0]     tmo_reg, tmo_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [1:0]        errcode_reg, errcode_next;
  logic              accept;
  logic              in_frame;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= S_HDR;
      inready_reg <= 1'b0;
      wren_reg    <= 1'b0;
      wrsel_reg   <= 1'b0;
      wraddr_reg  <= '0;
      wrdata_reg  <= '0;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      tmo_reg     <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      errcode_reg <= 2'b00;
    end else begin
      state_reg   <= state_next;
      inready_reg <= inready_next;
      wren_reg    <= wren_next;
      wrsel_reg   <= wrsel_next;
      wraddr_reg  <= wraddr_next;
      wrdata_reg  <= wrdata_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      acc_reg     <= acc_next;
      tmo_reg     <= tmo_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      errcode_reg <= errcode_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    wren_next    = 1'b0;
    wrsel_next   = wrsel_reg;
    wraddr_next  = wraddr_reg;
    wrdata_next  = wrdata_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    acc_next     = acc_reg;
    tmo_next     = tmo_reg;
    errcode_next = errcode_reg;
    accept       = InValid && inready_reg;
    in_frame     = (state_reg == S_CNT) || (state_reg == S_ADDR) ||
                   (state_reg == S_DATA) || (state_reg == S_CHK);

    case (state_reg)
      S_HDR: begin
        if (accept) begin
          if (InData == DATA_W'(8'h00) || InData == DATA_W'(8'h01)) begin
            wrsel_next = InData[0];
            acc_next   = '0;
            state_next = S_CNT;
          end else if (InData == DATA_W'(8'hFF)) begin
            state_next = S_DONE;
          end else begin
            state_next   = S_ERR;
            errcode_next = 2'b01;
          end
        end
      end
      S_CNT: begin
        if (accept) begin
          // A zero count means a full 2^DATA_W-byte segment.
          cnt_next   = (InData == '0) ? {1'b1, {DATA_W{1'b0}}} : {1'b0, InData};
          acc_next   = acc_reg ^ InData;
          state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (accept) begin
          ptr_next   = ADDR_W'(InData);
          acc_next   = acc_reg ^ InData;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          acc_next    = acc_reg ^ InData;
          wren_next   = 1'b1;
          wraddr_next = ptr_reg;
          wrdata_next = InData;
          ptr_next    = ptr_reg + ADDR_W'(1);
          cnt_next    = cnt_reg - (DATA_W+1)'(1);
          if (cnt_reg == (DATA_W+1)'(1)) state_next = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (InData == acc_reg) begin
            state_next = S_HDR;
          end else begin
            state_next   = S_ERR;
            errcode_next = 2'b10;
          end
        end
      end
      default: ;
    endcase

    // Idle counter only matters inside a frame; a stalled sender aborts the load.
    if (accept || state_reg == S_HDR) begin
      tmo_next = '0;
    end else if (in_frame && !InValid && TIMEOUT != 0) begin
      tmo_next = tmo_reg + TW'(1);
      if (tmo_next == TW'(TIMEOUT)) begin
        state_next   = S_ERR;
        errcode_next = 2'b11;
      end
    end

    inready_next = (state_next != S_DONE) && (state_next != S_ERR);
    done_next    = (state_next == S_DONE);
    err_next     = (state_next == S_ERR);
  end

  assign InReady = inready_reg;
  assign WrEn    = wren_reg;
  assign WrSel   = wrsel_reg;
  assign WrAddr  = wraddr_reg;
  assign WrData  = wrdata_reg;
  assign CpuRun  = done_reg;
  assign Done    = done_reg;
  assign Error   = err_reg;
  assign ErrCode = errcode_reg;

endmodule

// File: doc/nrisc_program_loader.md
Name: nrisc_program_loader

Overview:
- Byte-stream boot loader for the 8-bit nRisc platform.
- Accepts framed segments over a valid/ready byte interface and writes them into the instruction memory or the data memory through their write ports.
- Holds the processor stopped (CpuRun=0) until a valid end-of-program frame arrives.
- It is the writer side of the memory images that the processor and bench otherwise only read. It replaces file preload in hardware/FPGA builds.

Parameters:
- ADDR_W, 8, memory address width (instruction and data memories share it).
- DATA_W, 8, byte width of stream and memory words.
- TIMEOUT, 1023, max idle cycles waiting for InValid inside a frame before error; 0 disables the timeout.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- InData  in  8  stream byte.
- InValid  in  1  InData valid.
- InReady  out  1  loader can accept a byte; a transfer occurs when InValid&&InReady at a rising edge.
- WrEn  out  1  one-cycle memory write strobe.
- WrSel  out  1  0 = instruction memory, 1 = data memory.
- WrAddr  out  ADDR_W  write address.
- WrData  out  DATA_W  write data.
- CpuRun  out  1  1 = processor released; 0 = processor held at PC=0.
- Done  out  1  load completed successfully (sticky).
- Error  out  1  load aborted (sticky).
- ErrCode  out  2  01 = bad header, 10 = checksum mismatch, 11 = timeout, 00 = none.

Behaviour:
- Frame format: HDR, CNT, ADDR, CNT' data bytes, CHK.
  - HDR 0x00 selects instruction memory; 0x01 selects data memory; 0xFF ends the program (single byte, no further fields).
  - CNT=0 means 256 bytes.
  - ADDR is the start address.
  - CHK is the XOR of CNT, ADDR and all data bytes.
- States: S_HDR, S_CNT, S_ADDR, S_DATA, S_CHK, S_DONE, S_ERR.
- Reset (async, Reset=0) forces:
  - state S_HDR;
  - InReady=0, WrEn=0, WrSel=0, WrAddr=0, WrData=0;
  - CpuRun=0, Done=0, Error=0, ErrCode=00;
  - checksum accumulator, byte counter and timeout counter cleared.
- InReady is registered:
  - 0 in the first cycle after reset release;
  - 1 in S_HDR..S_CHK;
  - 0 in S_DONE/S_ERR.
- Transitions (each on an accepted byte):
  - S_HDR, 0x00/0x01: latch WrSel, clear accumulator, go to S_CNT.
  - S_HDR, 0xFF: go to S_DONE.
  - S_HDR, any other value: go to S_ERR, ErrCode=01.
  - S_CNT: latch count (0 loads 256 in a 9-bit counter), XOR into accumulator, go to S_ADDR.
  - S_ADDR: latch address pointer, XOR into accumulator, go to S_DATA.
  - S_DATA: XOR into accumulator, issue write, increment pointer, decrement count; go to S_CHK when count reaches 0.
  - S_CHK: if byte == accumulator, go to S_HDR (next frame); else go to S_ERR with ErrCode=10.
- Write timing:
  - WrEn pulses high for exactly one cycle, in the cycle after the data byte is accepted.
  - WrAddr/WrData are valid while WrEn=1 and hold their last value otherwise.
  - Back-to-back bytes produce back-to-back writes (throughput 1 byte/cycle).
- Address wrap: the pointer increments modulo 2^ADDR_W (0xFF -> 0x00). There is no error on wrap.
- Writes are not rolled back on checksum error; Error keeps the CPU held, so corrupt images never run.
- Timeout:
  - The counter runs in S_CNT/S_ADDR/S_DATA/S_CHK while InValid=0, and clears on every accepted byte and on entering S_HDR.
  - When it reaches TIMEOUT, go to S_ERR with ErrCode=11.
  - S_HDR never times out.
- S_DONE: Done=1 and CpuRun=1 from the cycle after 0xFF is accepted. Sticky until Reset.
- S_ERR: Error=1, CpuRun=0. Sticky until Reset.
- InValid with InReady=0 is ignored; the byte is not consumed.
- Reset mid-frame: immediate abort. No partial write strobe is emitted after Reset asserts; already-written bytes remain in memory.

Test Plan:
- Instruction frame: HDR 00, CNT 03, ADDR 10, data A1 B2 C3, CHK = 03^10^A1^B2^C3 = C3, then FF -> three WrEn pulses, WrSel=0, addr 10/11/12, data A1/B2/C3; Done=1 and CpuRun=1 one cycle after FF; Error=0.
- Data frame with wrap: HDR 01, CNT 02, ADDR FF, data 55 66, correct CHK -> writes at FF then 00, WrSel=1; back-to-back bytes give consecutive WrEn cycles.
- Bad checksum: frame 00 01 00 7E with CHK 00 -> one write of 7E at 00, then Error=1, ErrCode=10, InReady=0, CpuRun stays 0; a following FF is not accepted.
- Bad header 0x42 as first byte -> Error=1, ErrCode=01, no WrEn ever.
- Timeout with TIMEOUT=4: send 00 02, then hold InValid=0 -> Error=1, ErrCode=11 after 4 idle cycles. Repeat with InValid dropped 3 cycles between bytes -> no error.
- Async reset: assert Reset=0 mid S_DATA between clock edges -> outputs go to reset values immediately. After release, a full valid load succeeds.
